cp0_regfile: RTL

- MIPS32 coprocessor-0 register file: the consumer of the writeback stage's exception outputs (wb_except, wb_excode) and the source of cp0_data for mfc0 writeback.
- Commits exceptions and eret: updates Status/Cause/EPC/BadVAddr and issues a pipeline flush with a redirect PC.
- Runs the Count/Compare timer and produces the interrupt request that the pipeline injects back as ExcCode 0x00.

---
 rtl/cp0_regfile_pkg.sv | 49 ++++
 rtl/cp0_regfile_if.sv | 32 +++
 rtl/cp0_timer.sv | 50 +++++
 rtl/cp0_regfile.sv | 116 +++++++++++
 4 files changed

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause field positions.
package cp0_regfile_pkg;

  // CP0 register numbers (select 0 only)
  typedef enum logic [4:0] {
    CP0_BADVADDR = 5'd8,
    CP0_COUNT    = 5'd9,
    CP0_COMPARE  = 5'd11,
    CP0_STATUS   = 5'd12,
    CP0_CAUSE    = 5'd13,
    CP0_EPC      = 5'd14
  } cp0_reg_e;

  // Cause.ExcCode values raised by the pipeline
  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } excode_e;

  // Status field positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_IM_HI = 15;

  // Cause field positions
  localparam int unsigned CAUSE_EXC_LO  = 2;
  localparam int unsigned CAUSE_EXC_HI  = 6;
  localparam int unsigned CAUSE_IPSW_LO = 8;
  localparam int unsigned CAUSE_IPSW_HI = 9;
  localparam int unsigned CAUSE_IPHW_LO = 10;
  localparam int unsigned CAUSE_IPHW_HI = 15;
  localparam int unsigned CAUSE_TI      = 30;
  localparam int unsigned CAUSE_BD      = 31;

  // BEV is hardwired to 1
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  // Only address-error exceptions capture a faulting address
  function automatic logic is_addr_exc(input logic [4:0] excode);
    return (excode == EXC_ADEL) || (excode == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Pipeline <-> CP0 bundle: writeback exception/eret commit, mtc0/mfc0 access, interrupts, flush.
interface cp0_regfile_if;

  logic        wb_except;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic [31:0] wb_badvaddr;
  logic        wb_eret;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [5:0]  ext_int;
  logic [31:0] cp0_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        int_req;

  modport master (
    output wb_except, wb_excode, wb_pc, wb_bd, wb_badvaddr, wb_eret,
    output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, ext_int,
    input  cp0_data, flush, flush_pc, int_req
  );

  modport slave (
    input  wb_except, wb_excode, wb_pc, wb_bd, wb_badvaddr, wb_eret,
    input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, ext_int,
    output cp0_data, flush, flush_pc, int_req
  );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on Count reaching Compare.
module cp0_timer (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic [31:0] w_count_inc;

  assign w_count_inc = r_count + 32'd1;

  // Tick divider, Count/Compare writes, and TI set/clear (Compare write clear wins)
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_tick    <= 1'b0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (i_count_we) begin
        r_count <= i_wdata;
      end else if (r_tick) begin
        r_count <= w_count_inc;
      end
      if (i_compare_we) begin
        r_compare <= i_wdata;
      end
      if (i_compare_we) begin
        r_ti <= 1'b0;
      end else if (r_tick && !i_count_we && (w_count_inc == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file: exception/eret commit, mtc0/mfc0, timer and interrupt request.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input logic          i_clk,
  input logic          i_resetn,
  cp0_regfile_if.slave io_bus
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_mtc0_en;
  logic        w_count_we;
  logic        w_compare_we;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  // mtc0 loses to any same-cycle exception or eret
  assign w_mtc0_en    = io_bus.mtc0_we & ~io_bus.wb_except & ~io_bus.wb_eret;
  assign w_count_we   = w_mtc0_en & (io_bus.mtc0_addr == CP0_COUNT);
  assign w_compare_we = w_mtc0_en & (io_bus.mtc0_addr == CP0_COMPARE);

  cp0_timer u_timer (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_count_we  (w_count_we),
    .i_compare_we(w_compare_we),
    .i_wdata     (io_bus.mtc0_wdata),
    .o_count     (w_count),
    .o_compare   (w_compare),
    .o_ti        (w_ti)
  );

  // Commit exception > eret > mtc0; hardware IP lines are sampled every cycle
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_im       <= 8'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_hw    <= 6'd0;
      r_ip_sw    <= 2'd0;
      r_exccode  <= 5'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      r_ip_hw <= {io_bus.ext_int[5] | w_ti, io_bus.ext_int[4:0]};
      if (io_bus.wb_except) begin
        r_exccode <= io_bus.wb_excode;
        r_exl     <= 1'b1;
        // Nested exceptions keep the original return point
        if (!r_exl) begin
          r_epc <= io_bus.wb_bd ? (io_bus.wb_pc - 32'd4) : io_bus.wb_pc;
          r_bd  <= io_bus.wb_bd;
        end
        if (is_addr_exc(io_bus.wb_excode)) begin
          r_badvaddr <= io_bus.wb_badvaddr;
        end
      end else if (io_bus.wb_eret) begin
        r_exl <= 1'b0;
      end else if (w_mtc0_en) begin
        case (io_bus.mtc0_addr)
          CP0_STATUS: begin
            r_im  <= io_bus.mtc0_wdata[STATUS_IM_HI:STATUS_IM_LO];
            r_exl <= io_bus.mtc0_wdata[STATUS_EXL];
            r_ie  <= io_bus.mtc0_wdata[STATUS_IE];
          end
          CP0_CAUSE: r_ip_sw <= io_bus.mtc0_wdata[CAUSE_IPSW_HI:CAUSE_IPSW_LO];
          CP0_EPC:   r_epc   <= io_bus.mtc0_wdata;
          default:   ;
        endcase
      end
    end
  end

  // Assemble architectural Status/Cause views and the mfc0 read mux
  always_comb begin
    w_status                             = STATUS_RESET;
    w_status[STATUS_IM_HI:STATUS_IM_LO]  = r_im;
    w_status[STATUS_EXL]                 = r_exl;
    w_status[STATUS_IE]                  = r_ie;
    w_cause                              = 32'd0;
    w_cause[CAUSE_BD]                    = r_bd;
    w_cause[CAUSE_TI]                    = w_ti;
    w_cause[CAUSE_IPHW_HI:CAUSE_IPHW_LO] = r_ip_hw;
    w_cause[CAUSE_IPSW_HI:CAUSE_IPSW_LO] = r_ip_sw;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO]   = r_exccode;
    case (io_bus.mfc0_addr)
      CP0_BADVADDR: io_bus.cp0_data = r_badvaddr;
      CP0_COUNT:    io_bus.cp0_data = w_count;
      CP0_COMPARE:  io_bus.cp0_data = w_compare;
      CP0_STATUS:   io_bus.cp0_data = w_status;
      CP0_CAUSE:    io_bus.cp0_data = w_cause;
      CP0_EPC:      io_bus.cp0_data = r_epc;
      default:      io_bus.cp0_data = 32'd0;
    endcase
  end

  assign io_bus.flush    = io_bus.wb_except | io_bus.wb_eret;
  assign io_bus.flush_pc = io_bus.wb_except ? EXC_VECTOR : r_epc;
  assign io_bus.int_req  = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));

endmodule
